// File: rtl/pll_ctrl_pkg.sv
// Shared types for the PLL reconfiguration controller: the sequencer state
// encoding and the layout of one register-write table entry.
package pll_ctrl_pkg;

  localparam int PLL_AW = 6;
  localparam int PLL_DW = 8;

  typedef enum logic [2:0] {
    PRST,
    CFG,
    WLOCK,
    LOCKED,
    FAIL
  } state_t;

  typedef struct packed {
    logic [PLL_AW-1:0] addr;
    logic [PLL_DW-1:0] data;
  } tbl_entry_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer, cleared to 0 by the async reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// Sequences the PLL through reset, dynamic register writes and lock
// acquisition with timeout/retry, then supervises lock and relocks on loss.
module pll_reconfig_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int NUM_REGS     = 8,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int MAX_RETRY    = 3,
  parameter int LOCK_STABLE  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        tbl_we,
  input  logic [$clog2(NUM_REGS)-1:0] tbl_idx,
  input  logic [PLL_AW-1:0]           tbl_addr,
  input  logic [PLL_DW-1:0]           tbl_data,
  input  logic [$clog2(NUM_REGS):0]   tbl_cnt,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        fail,
  output logic                        locked,
  output logic                        lock_lost,
  output logic                        pll_reset,
  output logic                        pll_dcs,
  output logic                        pll_dwe,
  output logic [PLL_AW-1:0]           pll_daddr,
  output logic [PLL_DW-1:0]           pll_di,
  input  logic                        pll_extlock
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int CNT_W = IDX_W + 1;
  localparam int RC_W  = $clog2(RST_CYCLES + 1);
  localparam int CF_W  = $clog2(2 * NUM_REGS + 1);
  localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam int ST_W  = $clog2(LOCK_STABLE + 1);
  localparam int RT_W  = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0] NREG_C   = CNT_W'(NUM_REGS);
  localparam logic [RC_W-1:0]  RST_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(LOCK_STABLE - 1);
  localparam logic [RT_W-1:0]  RT_MAX   = RT_W'(MAX_RETRY);

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] c);
    return (c > NREG_C) ? NREG_C : c;
  endfunction

  state_t            state, state_n;
  tbl_entry_t        tbl     [NUM_REGS];
  tbl_entry_t        run_tbl [NUM_REGS];
  logic [CNT_W-1:0]  cnt;
  logic [RC_W-1:0]   rst_cnt;
  logic [CF_W-1:0]   cfg_cnt;
  logic [CF_W-1:0]   cfg_last;
  logic [TO_W-1:0]   tmo_cnt;
  logic [ST_W-1:0]   st_cnt;
  logic [RT_W-1:0]   retry;
  logic [RT_W-1:0]   retry_inc;
  logic [IDX_W-1:0]  wr_idx;
  logic              ext_sync;
  logic              start_acc, lost, lock_hit, timeout, wr;

  sync_2ff u_sync_extlock (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_extlock),
    .q     (ext_sync)
  );

  assign cfg_last  = CF_W'({cnt, 1'b0}) - CF_W'(1);
  assign retry_inc = retry + RT_W'(1);
  assign wr_idx    = IDX_W'(cfg_cnt >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= PRST;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    start_acc = 1'b0;
    lost      = 1'b0;
    lock_hit  = 1'b0;
    timeout   = 1'b0;
    case (state)
      PRST:   if (rst_cnt == RST_LAST) state_n = (cnt == '0) ? WLOCK : CFG;
      CFG:    if (cfg_cnt == cfg_last) state_n = WLOCK;
      WLOCK: begin
        if (ext_sync && st_cnt == ST_LAST) begin
          lock_hit = 1'b1;
          state_n  = LOCKED;
        end else if (tmo_cnt == TO_LAST) begin
          timeout = 1'b1;
          state_n = (retry_inc < RT_MAX) ? PRST : FAIL;
        end
      end
      // Lock loss takes priority over a coincident start request.
      LOCKED: begin
        if (!ext_sync) begin
          lost    = 1'b1;
          state_n = PRST;
        end else if (start) begin
          start_acc = 1'b1;
          state_n   = PRST;
        end
      end
      FAIL: begin
        if (start) begin
          start_acc = 1'b1;
          state_n   = PRST;
        end
      end
      default: state_n = PRST;
    endcase
  end

  // Write strobes and PLL reset are decoded from state so async reset forces them at once.
  assign wr        = (state == CFG) && !cfg_cnt[0];
  assign pll_dcs   = wr;
  assign pll_dwe   = wr;
  assign pll_daddr = wr ? run_tbl[wr_idx].addr : '0;
  assign pll_di    = wr ? run_tbl[wr_idx].data : '0;
  assign pll_reset = !((state == WLOCK) || (state == LOCKED));
  assign locked    = (state == LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_cnt   <= '0;
      cfg_cnt   <= '0;
      tmo_cnt   <= '0;
      st_cnt    <= '0;
      retry     <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      rst_cnt   <= (state == PRST  && state_n == PRST)  ? rst_cnt + RC_W'(1) : '0;
      cfg_cnt   <= (state == CFG   && state_n == CFG)   ? cfg_cnt + CF_W'(1) : '0;
      tmo_cnt   <= (state == WLOCK && state_n == WLOCK) ? tmo_cnt + TO_W'(1) : '0;
      st_cnt    <= (state == WLOCK && state_n == WLOCK && ext_sync) ? st_cnt + ST_W'(1) : '0;
      busy      <= (state_n == PRST) || (state_n == CFG) || (state_n == WLOCK);
      done      <= lock_hit;
      lock_lost <= lost;
      if (start_acc || lost) retry <= '0;
      else if (timeout)      retry <= retry_inc;
      if (start_acc) cnt <= sat_cnt(tbl_cnt);
      if (start_acc)                       fail <= 1'b0;
      else if (timeout && state_n == FAIL) fail <= 1'b1;
    end
  end

  // The snapshot is taken from the pre-edge table, so a write in the same cycle misses it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        tbl[i]     <= '0;
        run_tbl[i] <= '0;
      end
    end else begin
      if (tbl_we && !busy && ({1'b0, tbl_idx} < NREG_C))
        tbl[tbl_idx] <= '{addr: tbl_addr, data: tbl_data};
      if (start_acc || lost)
        run_tbl <= tbl;
    end
  end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl: boot, reprogramming, lock loss,
// illegal requests, timeout/retry exhaustion and async reset mid-write.
module tb_pll_reconfig_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tbl_we;
  logic [2:0] tbl_idx;
  logic [5:0] tbl_addr;
  logic [7:0] tbl_data;
  logic [3:0] tbl_cnt;
  logic       start;
  logic       busy, done, fail, locked, lock_lost;
  logic       pll_reset, pll_dcs, pll_dwe;
  logic [5:0] pll_daddr;
  logic [7:0] pll_di;
  logic       pll_extlock;

  int n_cmp = 0;
  int n_bad = 0;

  int         n_wr, low_at;
  int         wr_at   [16];
  logic [5:0] wr_addr [16];
  logic [7:0] wr_data [16];

  always #5 clk = ~clk;

  pll_reconfig_ctrl #(
    .NUM_REGS(8), .RST_CYCLES(4), .LOCK_TIMEOUT(20), .MAX_RETRY(3), .LOCK_STABLE(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tbl_we(tbl_we), .tbl_idx(tbl_idx),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data), .tbl_cnt(tbl_cnt), .start(start),
    .busy(busy), .done(done), .fail(fail), .locked(locked), .lock_lost(lock_lost),
    .pll_reset(pll_reset), .pll_dcs(pll_dcs), .pll_dwe(pll_dwe),
    .pll_daddr(pll_daddr), .pll_di(pll_di), .pll_extlock(pll_extlock)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Records writes from the current sample onward until pll_reset drops.
  task automatic capture_seq();
    n_wr   = 0;
    low_at = -1;
    for (int i = 0; i < 64; i++) begin
      if (pll_dcs && pll_dwe && n_wr < 16) begin
        wr_at[n_wr]   = i;
        wr_addr[n_wr] = pll_daddr;
        wr_data[n_wr] = pll_di;
        n_wr++;
      end
      if (!pll_reset) begin
        low_at = i;
        break;
      end
      step();
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 64) begin
      step();
      n++;
    end
  endtask

  task automatic write_entry(input int idx, input logic [5:0] a, input logic [7:0] d);
    tbl_we   = 1'b1;
    tbl_idx  = 3'(idx);
    tbl_addr = a;
    tbl_data = d;
    step();
    tbl_we   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tbl_we = 1'b0; tbl_idx = '0; tbl_addr = '0; tbl_data = '0;
    tbl_cnt = '0; start = 1'b0; pll_extlock = 1'b0;
    #3;
    n_cmp++; if (pll_reset !== 1'b1) begin n_bad++; $display("FAIL rst_pll_reset got %b want 1", pll_reset); end
    n_cmp++; if ({pll_dcs, pll_dwe} !== 2'b00) begin n_bad++; $display("FAIL rst_dcs_dwe got %b want 00", {pll_dcs, pll_dwe}); end
    n_cmp++; if ({pll_daddr, pll_di} !== 14'h0) begin n_bad++; $display("FAIL rst_addr_data got %h want 0", {pll_daddr, pll_di}); end
    n_cmp++; if ({busy, done, fail, locked, lock_lost} !== 5'b0) begin n_bad++; $display("FAIL rst_status got %b want 00000", {busy, done, fail, locked, lock_lost}); end
  endtask

  task automatic test_boot();
    int n;
    int dcs_seen;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL boot_busy got %b want 1", busy); end
    n = 1; dcs_seen = 0;
    while (pll_reset && n < 50) begin
      if (pll_dcs) dcs_seen++;
      step();
      n++;
    end
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL boot_prst_len got %0d want 4", n); end
    n_cmp++; if (dcs_seen !== 0) begin n_bad++; $display("FAIL boot_dcs_count got %0d want 0", dcs_seen); end
    repeat (10) step();
    pll_extlock = 1'b1;
    wait_done(n);
    n_cmp++; if (n !== 6) begin n_bad++; $display("FAIL boot_done_lat got %0d want 6", n); end
    n_cmp++; if ({locked, busy} !== 2'b10) begin n_bad++; $display("FAIL boot_locked_busy got %b want 10", {locked, busy}); end
    step();
    n_cmp++; if ({done, locked} !== 2'b01) begin n_bad++; $display("FAIL boot_done_pulse got %b want 01", {done, locked}); end
  endtask

  task automatic test_reconfig();
    int n;
    write_entry(0, 6'h05, 8'h0C);
    write_entry(1, 6'h11, 8'h14);
    start = 1'b1; tbl_cnt = 4'd2;
    step();
    start = 1'b0;
    n_cmp++; if ({busy, fail, locked} !== 3'b100) begin n_bad++; $display("FAIL reconf_accept got %b want 100", {busy, fail, locked}); end
    capture_seq();
    n_cmp++; if (n_wr !== 2) begin n_bad++; $display("FAIL reconf_nwr got %0d want 2", n_wr); end
    n_cmp++; if ({wr_at[0], wr_at[1]} !== {32'd4, 32'd6}) begin n_bad++; $display("FAIL reconf_wr_cycles got %0d,%0d want 4,6", wr_at[0], wr_at[1]); end
    n_cmp++; if ({wr_addr[0], wr_data[0]} !== {6'h05, 8'h0C}) begin n_bad++; $display("FAIL reconf_wr0 got %h/%h want 05/0c", wr_addr[0], wr_data[0]); end
    n_cmp++; if ({wr_addr[1], wr_data[1]} !== {6'h11, 8'h14}) begin n_bad++; $display("FAIL reconf_wr1 got %h/%h want 11/14", wr_addr[1], wr_data[1]); end
    n_cmp++; if (low_at !== 8) begin n_bad++; $display("FAIL reconf_reset_release got %0d want 8", low_at); end
    wait_done(n);
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL reconf_done_lat got %0d want 4", n); end
  endtask

  task automatic test_lock_loss();
    int n;
    pll_extlock = 1'b0;
    step();
    n = 1;
    pll_extlock = 1'b1;
    while (!lock_lost && n < 10) begin
      step();
      n++;
    end
    n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL loss_latency got %0d want 3", n); end
    n_cmp++; if ({locked, busy} !== 2'b01) begin n_bad++; $display("FAIL loss_locked_busy got %b want 01", {locked, busy}); end
    capture_seq();
    n_cmp++; if (n_wr !== 2) begin n_bad++; $display("FAIL loss_replay_nwr got %0d want 2", n_wr); end
    n_cmp++; if ({wr_addr[1], wr_data[1]} !== {6'h11, 8'h14}) begin n_bad++; $display("FAIL loss_replay_wr1 got %h/%h want 11/14", wr_addr[1], wr_data[1]); end
    n_cmp++; if (low_at !== 8) begin n_bad++; $display("FAIL loss_reset_release got %0d want 8", low_at); end
    wait_done(n);
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL loss_done_lat got %0d want 4", n); end
  endtask

  task automatic test_illegal();
    int n;
    for (int i = 0; i < 8; i++) write_entry(i, 6'(8'h20 + i), 8'(8'hA0 + i));
    start = 1'b1; tbl_cnt = 4'd12;
    step();
    // Second start and a table write while busy must both be ignored.
    tbl_we = 1'b1; tbl_idx = 3'd0; tbl_addr = 6'h3F; tbl_data = 8'hFF;
    step();
    start = 1'b0; tbl_we = 1'b0;
    capture_seq();
    n_cmp++; if (n_wr !== 8) begin n_bad++; $display("FAIL illegal_nwr got %0d want 8", n_wr); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if ({wr_addr[k], wr_data[k]} !== {6'(8'h20 + k), 8'(8'hA0 + k)} || wr_at[k] !== 3 + 2 * k) begin
        n_bad++;
        $display("FAIL illegal_wr%0d got %h/%h@%0d want %h/%h@%0d", k, wr_addr[k], wr_data[k],
                 wr_at[k], 6'(8'h20 + k), 8'(8'hA0 + k), 3 + 2 * k);
      end
    end
    n_cmp++; if (low_at !== 19) begin n_bad++; $display("FAIL illegal_reset_release got %0d want 19", low_at); end
    wait_done(n);
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL illegal_done_lat got %0d want 4", n); end
  endtask

  task automatic test_timeout();
    int n;
    pll_extlock = 1'b0; start = 1'b1; tbl_cnt = 4'd2;
    step();
    start = 1'b0;
    for (int a = 0; a < 3; a++) begin
      capture_seq();
      n_cmp++;
      if (n_wr !== 2 || {wr_addr[0], wr_data[0]} !== {6'h20, 8'hA0} || {wr_addr[1], wr_data[1]} !== {6'h21, 8'hA1}) begin
        n_bad++;
        $display("FAIL tmo_writes_try%0d got n=%0d %h/%h %h/%h want 2 20/a0 21/a1", a, n_wr,
                 wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
      end
      n_cmp++; if (low_at !== 8) begin n_bad++; $display("FAIL tmo_reset_release_try%0d got %0d want 8", a, low_at); end
      n = 0;
      while (!pll_reset && n < 100) begin
        step();
        n++;
      end
      n_cmp++; if (n !== 20) begin n_bad++; $display("FAIL tmo_wlock_len_try%0d got %0d want 20", a, n); end
      if (a < 2) begin
        n_cmp++; if ({busy, fail} !== 2'b10) begin n_bad++; $display("FAIL tmo_retry%0d_status got %b want 10", a, {busy, fail}); end
      end else begin
        n_cmp++; if ({busy, fail, pll_reset} !== 3'b011) begin n_bad++; $display("FAIL tmo_fail_status got %b want 011", {busy, fail, pll_reset}); end
      end
    end
    repeat (3) step();
    n_cmp++; if ({busy, fail, pll_dcs} !== 3'b010) begin n_bad++; $display("FAIL tmo_fail_sticky got %b want 010", {busy, fail, pll_dcs}); end
    pll_extlock = 1'b1; start = 1'b1; tbl_cnt = 4'd0;
    step();
    start = 1'b0;
    n_cmp++; if ({busy, fail} !== 2'b10) begin n_bad++; $display("FAIL tmo_start_clears got %b want 10", {busy, fail}); end
    wait_done(n);
    n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL tmo_restart_done_lat got %0d want 8", n); end
  endtask

  task automatic test_async_reset();
    int n;
    start = 1'b1; tbl_cnt = 4'd2;
    step();
    start = 1'b0;
    n = 0;
    while (!pll_dcs && n < 20) begin
      step();
      n++;
    end
    n_cmp++; if ({pll_dcs, pll_daddr} !== {1'b1, 6'h20} || n !== 4) begin n_bad++; $display("FAIL arst_pre_write got dcs=%b addr=%h at %0d want 1/20 at 4", pll_dcs, pll_daddr, n); end
    #2;
    rst_n = 1'b0;
    pll_extlock = 1'b0;
    #1;
    n_cmp++; if ({pll_dcs, pll_dwe, pll_reset} !== 3'b001) begin n_bad++; $display("FAIL arst_immediate got %b want 001", {pll_dcs, pll_dwe, pll_reset}); end
    n_cmp++; if ({busy, locked, pll_daddr, pll_di} !== 16'h0) begin n_bad++; $display("FAIL arst_outputs got %h want 0", {busy, locked, pll_daddr, pll_di}); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    while (pll_reset && n < 50) begin
      step();
      n++;
    end
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL arst_boot_len got %0d want 4", n); end
    pll_extlock = 1'b1;
    wait_done(n);
    n_cmp++; if (n !== 6) begin n_bad++; $display("FAIL arst_boot_done_lat got %0d want 6", n); end
    start = 1'b1; tbl_cnt = 4'd2;
    step();
    start = 1'b0;
    capture_seq();
    n_cmp++;
    if (n_wr !== 2 || {wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]} !== 28'h0) begin
      n_bad++;
      $display("FAIL arst_table_cleared got n=%0d %h/%h %h/%h want 2 00/00 00/00", n_wr,
               wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
    end
    wait_done(n);
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL arst_final_done_lat got %0d want 4", n); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_boot();
    test_reconfig();
    test_lock_loss();
    test_illegal();
    test_timeout();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
